// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register specifiers and the
// writeback scheduler state encoding.
package y86_pkg;

    localparam int unsigned REG_W = 4;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [REG_W-1:0] REG_RSP  = 4'h4;
    localparam logic [REG_W-1:0] REG_NONE = 4'hF;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_PEND_M = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_dst_decode.sv
// Maps a writeback request's icode/cnd/rA/rB to its E and M destinations.
// A destination of REG_NONE means that write is skipped.
module wb_dst_decode
    import y86_pkg::*;
(
    input  logic [3:0]       in_code,
    input  logic             cnd,
    input  logic [REG_W-1:0] ra,
    input  logic [REG_W-1:0] rb,
    output logic [REG_W-1:0] dst_e,
    output logic [REG_W-1:0] dst_m,
    output logic             illegal
);

    always_comb begin
        dst_e   = REG_NONE;
        dst_m   = REG_NONE;
        illegal = 1'b0;
        case (in_code)
            I_RRMOVQ: begin
                if (cnd) dst_e = rb;
            end
            I_IRMOVQ, I_OPQ: dst_e = rb;
            I_MRMOVQ:        dst_m = ra;
            I_CALL, I_RET, I_PUSHQ: dst_e = REG_RSP;
            I_POPQ: begin
                dst_e = REG_RSP;
                dst_m = ra;
            end
            I_HALT, I_NOP, I_RMMOVQ, I_JXX: begin
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/regfile_write_sched.sv
// Single-write-port scheduler for the SEQ register file: serialises E/M
// writebacks (E first) and arbitrates a host write port with bounded starvation.
module regfile_write_sched
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W          = 64,
    parameter int unsigned HOST_STARVE_MAX = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [3:0]        in_code,
    input  logic              cnd,
    input  logic [REG_W-1:0]  ra,
    input  logic [REG_W-1:0]  rb,
    input  logic [DATA_W-1:0] val_e,
    input  logic [DATA_W-1:0] val_m,
    input  logic              host_req,
    input  logic [REG_W-1:0]  host_addr,
    input  logic [DATA_W-1:0] host_data,
    output logic              host_gnt,
    output logic              rf_wen,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              err
);

    localparam int unsigned STARVE_W = 4;
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(HOST_STARVE_MAX);

    wb_state_t           state_q, state_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic [REG_W-1:0]    pend_addr_q, pend_addr_d;
    logic [DATA_W-1:0]   pend_data_q, pend_data_d;
    logic                wen_d;
    logic [REG_W-1:0]    waddr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic                err_d;
    logic [REG_W-1:0]    dst_e, dst_m;
    logic                illegal;

    wb_dst_decode u_dst_decode (
        .in_code (in_code),
        .cnd     (cnd),
        .ra      (ra),
        .rb      (rb),
        .dst_e   (dst_e),
        .dst_m   (dst_m),
        .illegal (illegal)
    );

    // Next-state, arbitration and next write-port values
    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        wen_d       = 1'b0;
        waddr_d     = REG_NONE;
        wdata_d     = '0;
        err_d       = 1'b0;
        host_gnt    = 1'b0;
        wb_ready    = 1'b0;

        case (state_q)
            S_IDLE: begin
                host_gnt = reset_n && host_req && (!wb_valid || (starve_q == STARVE_MAX));
                wb_ready = reset_n && !host_gnt;
                if (host_gnt) begin
                    starve_d = '0;
                    if (host_addr == REG_NONE) begin
                        err_d = 1'b1;
                    end else begin
                        wen_d   = 1'b1;
                        waddr_d = host_addr;
                        wdata_d = host_data;
                    end
                end else begin
                    if (!host_req) begin
                        starve_d = '0;
                    end else if (starve_q != STARVE_MAX) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                    if (wb_valid && wb_ready) begin
                        err_d = illegal;
                        // E always goes first so popq %rsp ends with valM in %rsp
                        if (dst_e != REG_NONE) begin
                            wen_d   = 1'b1;
                            waddr_d = dst_e;
                            wdata_d = val_e;
                            if (dst_m != REG_NONE) begin
                                state_d     = S_PEND_M;
                                pend_addr_d = dst_m;
                                pend_data_d = val_m;
                            end
                        end else if (dst_m != REG_NONE) begin
                            wen_d   = 1'b1;
                            waddr_d = dst_m;
                            wdata_d = val_m;
                        end
                    end
                end
            end
            S_PEND_M: begin
                wen_d   = 1'b1;
                waddr_d = pend_addr_q;
                wdata_d = pend_data_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            starve_q    <= '0;
            pend_addr_q <= REG_NONE;
            pend_data_q <= '0;
            rf_wen      <= 1'b0;
            rf_waddr    <= REG_NONE;
            rf_wdata    <= '0;
            err         <= 1'b0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            rf_wen      <= wen_d;
            rf_waddr    <= waddr_d;
            rf_wdata    <= wdata_d;
            err         <= err_d;
        end
    end

endmodule
